// File: rtl/decoder_pipe.sv
// decoder_pipe: registered 3-to-8 binary-to-one-hot decoder.
// A valid/ready handshake is used on both sides. Storage is the output
// register (OREG) plus a one-entry skid register (SREG), in FIFO order.
// A wrap-around count of delivered vectors is kept for debug.
module decoder_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       din,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // One-hot decode of a code.
    // A disabled word is all-zero but still occupies a storage slot.
    function automatic logic [7:0] decode_word(input logic [2:0] code, input logic enable);
        logic [7:0] word;
        word = 8'h00;
        if (enable) begin
            case (code)
                3'd0:    word = 8'h01;
                3'd1:    word = 8'h02;
                3'd2:    word = 8'h04;
                3'd3:    word = 8'h08;
                3'd4:    word = 8'h10;
                3'd5:    word = 8'h20;
                3'd6:    word = 8'h40;
                3'd7:    word = 8'h80;
                default: word = 8'h00;
            endcase
        end else begin
            word = 8'h00;
        end
        return word;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       oreg_r;
    logic [7:0]       oreg_nxt_s;
    logic [7:0]       sreg_r;
    logic [7:0]       sreg_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       word_s;
    logic             acc_s;
    logic             pop_s;

    // Handshake qualifiers.
    // They use only registered ready/valid, so no combinational path exists
    // from out_ready to in_ready.
    assign acc_s  = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;
    assign word_s = decode_word(din, en);

    // Next-state and next-data selection for the OREG/SREG queue.
    always_comb begin
        state_nxt_s = state_r;
        oreg_nxt_s  = oreg_r;
        sreg_nxt_s  = sreg_r;
        case (state_r)
            ST_EMPTY: begin
                if (acc_s) begin
                    state_nxt_s = ST_ONE;
                    oreg_nxt_s  = word_s;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (acc_s && !pop_s) begin
                    state_nxt_s = ST_FULL;
                    sreg_nxt_s  = word_s;
                end else if (pop_s && !acc_s) begin
                    state_nxt_s = ST_EMPTY;
                    oreg_nxt_s  = 8'h00;
                end else if (acc_s && pop_s) begin
                    state_nxt_s = ST_ONE;
                    oreg_nxt_s  = word_s;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_nxt_s = ST_ONE;
                    oreg_nxt_s  = sreg_r;
                    sreg_nxt_s  = 8'h00;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
                oreg_nxt_s  = 8'h00;
                sreg_nxt_s  = 8'h00;
            end
        endcase
    end

    // State, data and registered handshake flags.
    // Reset has priority and discards any held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            oreg_r      <= 8'h00;
            sreg_r      <= 8'h00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            oreg_r      <= oreg_nxt_s;
            sreg_r      <= sreg_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Delivered-vector counter.
    // It advances only on an output transfer and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (pop_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dout      = oreg_r;
    assign count     = count_r;

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe.
// The reference model is a bounded queue of decoded words plus a pop
// tally. It is stepped once per clock from the stimulus the bench drives.
module tb_decoder_pipe;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       din;
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       dout;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    decoder_pipe #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_q[$];
    int         model_pops = 0;
    string      phase = "init";

    // Single comparison point: count it, and report any mismatch.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s [%s] t=%0t: observed=0x%0h expected=0x%0h", tag, phase, $time, obs, exp);
        end
    endtask

    // One clock of stimulus.
    // Drive the inputs, advance the model at the edge, then compare at the
    // falling edge.
    task automatic step(input logic r, input logic iv, input logic [2:0] d,
                        input logic e, input logic ordy);
        logic       acc;
        logic       pop;
        logic [7:0] w;
        rst       = r;
        in_valid  = iv;
        din       = d;
        en        = e;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_pops = 0;
        end else begin
            acc = iv && (model_q.size() < 2);
            pop = ordy && (model_q.size() > 0);
            w   = e ? 8'(2 ** int'(d)) : 8'd0;
            if (pop) begin
                void'(model_q.pop_front());
                model_pops++;
            end
            if (acc) model_q.push_back(w);
        end
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        check_eq("dout",      32'(dout),      (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
        check_eq("in_ready",  32'(in_ready),  32'(model_q.size() < 2));
        check_eq("count",     32'(count),     32'(model_pops % (1 << CNT_W)));
    endtask

    initial begin
        // Reset held for two cycles while a valid code is offered.
        phase = "reset";
        step(1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 3'd5, 1'b1, 1'b1);

        // Full-throughput sweep of every code.
        phase = "sweep";
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        check_eq("sweep_count", 32'(count), 32'd0);

        // A disabled word is delivered as all-zero.
        phase = "disable";
        step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
        check_eq("dis_dout", 32'(dout), 32'h00);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Backpressure: fill both slots, then drain in order.
        phase = "backpressure";
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
        check_eq("bp_hold", 32'(dout), 32'h04);
        check_eq("bp_full", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b1);
        check_eq("bp_second", 32'(dout), 32'h10);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b1);
        check_eq("bp_late", 32'(dout), 32'h02);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Simultaneous accept and pop while one word is held.
        phase = "acc_pop";
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd7, 1'b1, 1'b1);
        check_eq("ap_dout", 32'(dout), 32'h80);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Reset while both slots are occupied.
        phase = "rst_full";
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        check_eq("rf_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Counter wrap: nine pops from a fresh reset.
        phase = "wrap";
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 3'(i % 8), 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        check_eq("wrap_count", 32'(count), 32'd1);

        // Randomized traffic with bursty backpressure and rare resets.
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 ((i / 16) % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Registered 3-to-8 binary-to-one-hot decoder with valid/ready handshakes on both sides and a one-entry skid buffer. It is the inverse of the team's 8-to-3 priority encoder. It converts a stream of 3-bit codes back into one-hot select vectors for downstream consumers that may stall. It also keeps a wrap-around count of delivered vectors for debug.

## Interface
- CNT_W, 8, width of the delivered-vector counter
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- din  input  3  binary code to decode
- en  input  1  decode enable, sampled together with din on acceptance
- in_valid  input  1  din/en are valid
- in_ready  output  1  block can accept a code this cycle
- dout  output  8  one-hot decoded vector: bit[din] = 1, or all-zero if disabled
- out_valid  output  1  dout holds a valid vector
- out_ready  input  1  downstream accepts dout this cycle
- count  output  CNT_W  number of output transfers, modulo 2^CNT_W

## Operation
- Input transfer (acc): in_valid && in_ready at a rising edge.
- Output transfer (pop): out_valid && out_ready at a rising edge.
- Decode of an accepted word: if en=1, the word is 8'b1 << din. If en=0, the word is 8'h00. A disabled word still occupies a slot and is still delivered.
- Storage is the output register (OREG) plus one skid register (SREG). Order is strictly FIFO.
- States:
  - EMPTY: out_valid=0, dout=8'h00.
  - ONE: OREG valid, SREG empty.
  - FULL: OREG and SREG both valid.
- in_ready = (state != FULL). It is a pure function of the state register, so it has no combinational path from in_valid or out_ready.
- Transitions:
  - EMPTY: acc -> ONE, OREG <= decode. Otherwise stay in EMPTY.
  - ONE: acc && !pop -> FULL, SREG <= decode.
  - ONE: pop && !acc -> EMPTY, dout <= 8'h00.
  - ONE: acc && pop -> ONE, OREG <= decode.
  - ONE: neither -> hold.
  - FULL: pop -> ONE, OREG <= SREG. Otherwise hold. No acc is possible in FULL.
- out_valid = (state != EMPTY). dout reflects OREG while out_valid=1 and is 8'h00 while out_valid=0.
- count increments by 1 on every pop and wraps from 2^CNT_W-1 to 0. Accepts, en, and stalls do not affect count.
- dout and out_valid must stay stable while out_valid=1 && out_ready=0.
- rst has priority over acc and pop in the same cycle. Any words held in OREG/SREG are discarded.

## Timing
- Reset values (registered at the first edge with rst=1): state EMPTY, out_valid 0, dout 8'h00, count 0, in_ready 1.
- Latency: a word accepted at edge N appears on dout with out_valid=1 immediately after edge N, provided it is at the head of the queue.
- Throughput: with out_ready held high, one word per cycle and in_ready is never deasserted.
- After out_ready is dropped, at most 2 words are buffered. in_ready falls right after the edge that fills SREG.
- in_ready returns to 1 right after the first edge where pop occurs in FULL. A new acc is possible on the following cycle.
- All outputs are registered or depend only on registered state.

## Test plan
- Reset: drive rst=1 for 2 cycles with in_valid=1 and din=3'd5 -> out_valid=0, dout=8'h00, count=0, in_ready=1 throughout; no word is captured.
- Sweep: out_ready=1, en=1, feed din=0..7 on consecutive cycles -> dout = 8'h01, 02, 04, 08, 10, 20, 40, 80, each one cycle after its accept; count=8; in_ready stays 1.
- Disable: accept din=3'd6 with en=0 -> dout=8'h00 with out_valid=1; count increments by 1 on the pop.
- Backpressure: out_ready=0, feed din=2, 4, 1 -> 2 and 4 accepted, in_ready=0 after the second, dout holds 8'h04. Then raise out_ready -> 8'h04 then 8'h10 are delivered in order, and din=1 is accepted only after in_ready returns high.
- Simultaneous accept and pop in ONE: dout changes to the new code in the same edge, state stays ONE, and no word is lost.
- Counter wrap with CNT_W=3: perform 9 pops -> count reads 7 then 0 then 1. Separately, assert rst while in FULL -> both words are dropped and the reset values are restored next cycle.
